// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// The round-robin pick rule lives here so the top stays a thin mux/demux shell.
package sram_arbiter_pkg;

   localparam int unsigned DefAddrW = 17;
   localparam int unsigned DefDataW = 8;

   localparam int unsigned PortSpi = 0;
   localparam int unsigned PortAux = 1;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStrobe,
      StHold
   } cycle_state_e;

   // One-hot grant from {p1_req, p0_req}; on a tie the port that did not win last time wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_gnt);
      logic [1:0] gnt;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
      return gnt;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of the SRAM arbiter: two request ports, done pulses, read data, owner.
interface sram_arbiter_if
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW
);

   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_done;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_done;

   logic [DATA_W-1:0] rdata;
   logic [1:0]        busy;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p0_done, p1_done, rdata, busy
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p0_done, p1_done, rdata, busy
   );

endinterface

// File: rtl/sram_arbiter_cycle_fsm.sv
// Single-requester SRAM cycle sequencer: IDLE -> SETUP -> STROBE x STROBE_CYC -> HOLD.
// Every pin, including the data-bus drive enable, comes straight from a flop.
module sram_arbiter_cycle_fsm
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = DefAddrW,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned STROBE_CYC = 2
) (
   input  logic              sclk,
   input  logic              rst_l,
   input  logic              start,
   input  logic [1:0]        owner,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              idle,
   output logic [1:0]        busy,
   output logic [1:0]        done,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_address_ext,
   inout  wire  [DATA_W-1:0] ram_data_ext,
   output logic              ce_l,
   output logic              ce2,
   output logic              we_l,
   output logic              oe_l
);

   localparam int unsigned CntW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(STROBE_CYC - 1);

   cycle_state_e      state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              drive_q, drive_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ce_l_q, ce_l_d;
   logic              ce2_q, ce2_d;
   logic              we_l_q, we_l_d;
   logic              oe_l_q, oe_l_d;
   logic [1:0]        busy_q, busy_d;
   logic [1:0]        done_q, done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      drive_d = drive_q;
      addr_d  = addr_q;
      ce_l_d  = ce_l_q;
      ce2_d   = ce2_q;
      we_l_d  = 1'b1;
      oe_l_d  = 1'b1;
      busy_d  = busy_q;
      done_d  = 2'b00;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSetup;
               we_d    = we;
               wdata_d = wdata;
               addr_d  = addr;
               drive_d = we;
               ce_l_d  = 1'b0;
               ce2_d   = 1'b1;
               busy_d  = owner;
            end
         end
         StSetup: begin
            state_d = StStrobe;
            cnt_d   = CntLoad;
            we_l_d  = ~we_q;
            oe_l_d  = we_q;
         end
         StStrobe: begin
            if (cnt_q == '0) begin
               // Strobes rise into HOLD; a read samples the SRAM on this same edge.
               state_d = StHold;
               done_d  = busy_q;
               if (!we_q) begin
                  rdata_d = ram_data_ext;
               end
            end else begin
               cnt_d  = cnt_q - CntW'(1);
               we_l_d = ~we_q;
               oe_l_d = we_q;
            end
         end
         StHold: begin
            state_d = StIdle;
            drive_d = 1'b0;
            ce_l_d  = 1'b1;
            ce2_d   = 1'b0;
            busy_d  = 2'b00;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (!rst_l) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         drive_q <= 1'b0;
         addr_q  <= '0;
         ce_l_q  <= 1'b1;
         ce2_q   <= 1'b0;
         we_l_q  <= 1'b1;
         oe_l_q  <= 1'b1;
         busy_q  <= 2'b00;
         done_q  <= 2'b00;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         drive_q <= drive_d;
         addr_q  <= addr_d;
         ce_l_q  <= ce_l_d;
         ce2_q   <= ce2_d;
         we_l_q  <= we_l_d;
         oe_l_q  <= oe_l_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   assign idle            = (state_q == StIdle);
   assign busy            = busy_q;
   assign done            = done_q;
   assign rdata           = rdata_q;
   assign ram_address_ext = addr_q;
   assign ce_l            = ce_l_q;
   assign ce2             = ce2_q;
   assign we_l            = we_l_q;
   assign oe_l            = oe_l_q;
   assign ram_data_ext    = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin front end for the external 128Kx8 SRAM: picks a requester in IDLE,
// muxes its command into the cycle sequencer and routes the done pulse back to it.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = DefAddrW,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned STROBE_CYC = 2
) (
   input  logic              sclk,
   input  logic              rst_l,
   sram_arbiter_if.slave     host,
   output logic [ADDR_W-1:0] ram_address_ext,
   inout  wire  [DATA_W-1:0] ram_data_ext,
   output logic              ce_l,
   output logic              ce2,
   output logic              we_l,
   output logic              oe_l
);

   logic              last_gnt_q, last_gnt_d;
   logic              idle;
   logic [1:0]        gnt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        done;

   // Requests only count while the sequencer is idle; anything else is ignored.
   always_comb begin
      gnt        = idle ? rr_pick({host.p1_req, host.p0_req}, last_gnt_q) : 2'b00;
      last_gnt_d = last_gnt_q;
      if (idle && host.p0_req && host.p1_req) begin
         last_gnt_d = gnt[PortAux];
      end
      sel_we    = gnt[PortAux] ? host.p1_we    : host.p0_we;
      sel_addr  = gnt[PortAux] ? host.p1_addr  : host.p0_addr;
      sel_wdata = gnt[PortAux] ? host.p1_wdata : host.p0_wdata;
   end

   always_ff @(posedge sclk) begin
      if (!rst_l) begin
         last_gnt_q <= 1'b1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

   sram_arbiter_cycle_fsm #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STROBE_CYC (STROBE_CYC)
   ) u_cycle (
      .sclk            (sclk),
      .rst_l           (rst_l),
      .start           (|gnt),
      .owner           (gnt),
      .we              (sel_we),
      .addr            (sel_addr),
      .wdata           (sel_wdata),
      .idle            (idle),
      .busy            (host.busy),
      .done            (done),
      .rdata           (host.rdata),
      .ram_address_ext (ram_address_ext),
      .ram_data_ext    (ram_data_ext),
      .ce_l            (ce_l),
      .ce2             (ce2),
      .we_l            (we_l),
      .oe_l            (oe_l)
   );

   assign host.p0_done = done[PortSpi];
   assign host.p1_done = done[PortAux];

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM on the pins, a transaction-level reference model
// (round-robin rule, expected memory contents, per-phase pin expectations) and random traffic.
module tb_sram_arbiter;

   localparam int unsigned AW = 17;
   localparam int unsigned DW = 8;
   localparam int unsigned S  = 2;

   logic          sclk;
   logic          rst_l;
   logic [AW-1:0] ram_address_ext;
   wire  [DW-1:0] ram_data_ext;
   logic          ce_l, ce2, we_l, oe_l;

   sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host_if ();

   sram_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STROBE_CYC (S)
   ) dut (
      .sclk            (sclk),
      .rst_l           (rst_l),
      .host            (host_if),
      .ram_address_ext (ram_address_ext),
      .ram_data_ext    (ram_data_ext),
      .ce_l            (ce_l),
      .ce2             (ce2),
      .we_l            (we_l),
      .oe_l            (oe_l)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   // Behavioural asynchronous SRAM
   logic [DW-1:0] sram_mem [0:(1<<AW)-1];
   assign ram_data_ext = (ce_l === 1'b0 && ce2 === 1'b1 && oe_l === 1'b0) ?
                         sram_mem[ram_address_ext] : {DW{1'bz}};
   always @(posedge sclk) begin
      if (ce_l === 1'b0 && ce2 === 1'b1 && we_l === 1'b0) begin
         sram_mem[ram_address_ext] <= ram_data_ext;
      end
   end

   function automatic logic [DW-1:0] init_byte(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // Reference model state
   logic [DW-1:0] ref_mem [int];
   logic          last_gnt;
   int            last_won;
   logic          pend    [2];
   logic          p_we    [2];
   logic [AW-1:0] p_addr  [2];
   logic [DW-1:0] p_wdata [2];

   int n_checks;
   int n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_byte(a);
   endfunction

   // {ce_l, ce2, we_l, oe_l, busy[1:0], p1_done, p0_done}
   function automatic logic [7:0] pins();
      return {ce_l, ce2, we_l, oe_l, host_if.busy, host_if.p1_done, host_if.p0_done};
   endfunction

   task automatic apply();
      host_if.p0_req   = pend[0];
      host_if.p0_we    = p_we[0];
      host_if.p0_addr  = p_addr[0];
      host_if.p0_wdata = p_wdata[0];
      host_if.p1_req   = pend[1];
      host_if.p1_we    = p_we[1];
      host_if.p1_addr  = p_addr[1];
      host_if.p1_wdata = p_wdata[1];
   endtask

   task automatic post(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      pend[p]    = 1'b1;
      p_we[p]    = we;
      p_addr[p]  = a;
      p_wdata[p] = d;
   endtask

   task automatic raise(input int p);
      post(p, 1'($urandom_range(0, 1)), AW'(17'h00100 + $urandom_range(0, 15)),
           DW'($urandom));
   endtask

   // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE.
   task automatic run_access(output int obs_w);
      int            w;
      logic          tie;
      logic [1:0]    oh;
      logic [DW-1:0] rexp;
      obs_w = -1;
      apply();
      check("idle_pins", pins(), {4'b1011, 4'b0000});
      if (!pend[0] && !pend[1]) begin
         last_won = -1;
         @(negedge sclk);
         return;
      end
      tie = pend[0] && pend[1];
      if (tie) w = last_gnt ? 0 : 1;
      else     w = pend[0] ? 0 : 1;
      if (tie) last_gnt = (w == 1);
      oh   = (w == 0) ? 2'b01 : 2'b10;
      rexp = ref_read(p_addr[w]);

      @(negedge sclk);
      check("setup_pins", pins(), {4'b0111, oh, 2'b00});
      check("setup_addr", ram_address_ext, p_addr[w]);
      if (p_we[w]) check("setup_bus", ram_data_ext, p_wdata[w]);
      for (int s = 0; s < S; s++) begin
         @(negedge sclk);
         check("strobe_pins", pins(), {2'b01, ~p_we[w], p_we[w], oh, 2'b00});
         check("strobe_addr", ram_address_ext, p_addr[w]);
         check("strobe_bus", ram_data_ext, p_we[w] ? p_wdata[w] : rexp);
      end
      @(negedge sclk);
      check("hold_pins", pins(), {4'b0111, oh, oh});
      check("hold_addr", ram_address_ext, p_addr[w]);
      if (p_we[w]) begin
         check("hold_bus", ram_data_ext, p_wdata[w]);
         ref_mem[int'(p_addr[w])] = p_wdata[w];
      end else begin
         check("rdata", host_if.rdata, rexp);
      end
      if (host_if.p1_done === 1'b1)      obs_w = 1;
      else if (host_if.p0_done === 1'b1) obs_w = 0;
      pend[w]  = 1'b0;
      last_won = w;
      apply();
      @(negedge sclk);
   endtask

   initial begin
      int obs;
      n_checks = 0;
      n_pass   = 0;
      last_gnt = 1'b1;
      last_won = -1;
      for (int p = 0; p < 2; p++) post(p, 1'b0, '0, '0);
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int a = 0; a < (1 << AW); a++) sram_mem[a] = init_byte(AW'(a));
      sram_mem[17'h1A5A5]       = 8'h3C;
      ref_mem[int'(17'h1A5A5)]  = 8'h3C;
      apply();

      rst_l = 1'b0;
      repeat (2) @(posedge sclk);
      @(negedge sclk);
      check("rst_pins", pins(), {4'b1011, 4'b0000});
      check("rst_addr", ram_address_ext, '0);
      check("rst_rdata", host_if.rdata, '0);
      rst_l = 1'b1;
      repeat (10) run_access(obs);

      // Directed write then directed read of the preloaded location.
      post(0, 1'b1, 17'h0006C, 8'h73);
      run_access(obs);
      check("wr_done_port", obs, 0);
      post(0, 1'b0, 17'h1A5A5, 8'h00);
      run_access(obs);
      check("rd_done_port", obs, 0);

      // Random traffic on both ports; a port just served stays low for one IDLE.
      for (int i = 0; i < 60; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && p != last_won && $urandom_range(0, 2) != 0) raise(p);
         end
         run_access(obs);
      end
      for (int i = 0; i < 3 && (pend[0] || pend[1]); i++) run_access(obs);

      // Reset during the first STROBE cycle of a port 1 write.
      post(1, 1'b1, 17'h1F000, 8'hA5);
      apply();
      check("abort_idle", pins(), {4'b1011, 4'b0000});
      @(negedge sclk);
      check("abort_setup", pins(), {4'b0111, 2'b10, 2'b00});
      @(negedge sclk);
      check("abort_strobe", pins(), {4'b0101, 2'b10, 2'b00});
      rst_l = 1'b0;
      @(negedge sclk);
      check("abort_pins", pins(), {4'b1011, 4'b0000});
      check("abort_addr", ram_address_ext, '0);
      check("abort_rdata", host_if.rdata, '0);
      rst_l    = 1'b1;
      pend[1]  = 1'b0;
      last_gnt = 1'b1;
      last_won = -1;

      // Both ports keep requesting: grants must alternate starting with port 0.
      raise(0);
      raise(1);
      for (int k = 0; k < 6; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && p != last_won) raise(p);
         end
         run_access(obs);
         check("rr_order", obs, k % 2);
      end
      for (int i = 0; i < 3 && (pend[0] || pend[1]); i++) run_access(obs);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Owns the external 128Kx8 SRAM pins and shares them between two requesters.
- Port 0 is the SPI command path. It issues a read or write for each decoded address/data byte pair.
- Port 1 is an auxiliary engine, for example a pattern fill or LED refresh.
- The block picks one request round-robin, then sequences a single SRAM cycle through SETUP/STROBE/HOLD.
- It returns a one-cycle done pulse and, for reads, the read data.

Parameters:
- ADDR_W, 17, SRAM address width.
- DATA_W, 8, SRAM data width.
- STROBE_CYC, 2, number of cycles oe_l/we_l stay asserted (minimum 1).

Ports:
- sclk  in  1  block clock; all logic runs on the rising edge.
- rst_l  in  1  reset, synchronous and active-low.
- p0_req  in  1  port 0 request, level.
- p0_we  in  1  port 0 type: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_done  out  1  port 0 access complete, one-cycle pulse.
- p1_req, p1_we, p1_addr, p1_wdata, p1_done: port 1, same as the port 0 signals.
- rdata  out  DATA_W  read data; valid while the corresponding pN_done is high.
- busy  out  2  one-hot owner of the current cycle: bit0 = port 0, bit1 = port 1; 00 when idle.
- ram_address_ext  out  ADDR_W  SRAM address.
- ram_data_ext  inout  DATA_W  SRAM data bus, tristated by this block.
- ce_l  out  1  SRAM chip enable, active low.
- ce2  out  1  SRAM chip enable, active high.
- we_l  out  1  SRAM write strobe, active low.
- oe_l  out  1  SRAM output enable, active low.

Behaviour:
- All outputs are registered. The data bus drive enable is registered too.
- Reset values (applied at the first edge with rst_l = 0):
  - FSM in IDLE.
  - ce_l = 1, ce2 = 0, we_l = 1, oe_l = 1.
  - ram_data_ext hi-Z, ram_address_ext = 0.
  - rdata = 0, busy = 00, p0_done = p1_done = 0.
  - last_gnt = 1, so port 0 wins the first tie.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, that port is granted.
  - If both are high, the port that is not last_gnt is granted, and last_gnt is updated to the winner.
  - On grant, latch we/addr/wdata, set busy, and go to SETUP.
  - With no req, stay in IDLE.
- SETUP (1 cycle):
  - Address driven; ce_l = 0, ce2 = 1; we_l = oe_l = 1.
  - Write: data bus driven with the latched wdata. Read: data bus hi-Z.
- STROBE (STROBE_CYC cycles, counted by a down-counter):
  - Read: oe_l = 0.
  - Write: we_l = 0, data still driven.
  - On a read, ram_data_ext is captured into rdata at the edge that leaves the last STROBE cycle.
- HOLD (1 cycle):
  - we_l = oe_l = 1; address and ce held.
  - Write: data still driven, giving data hold time past the rising edge of we_l.
  - The winning pN_done is 1 for exactly this cycle; rdata is valid.
- After HOLD:
  - Go to IDLE; ce_l = 1, ce2 = 0, bus released, busy = 00.
- Latency:
  - Request seen in IDLE at cycle N gives done at cycle N + 2 + STROBE_CYC (N + 4 at the default).
  - One IDLE cycle always separates consecutive accesses, so the bus turns around between cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable from assertion until it samples done.
  - Requester deasserts req on the edge where it samples done, so req is low in the following IDLE.
  - A req still high in that IDLE counts as a new access.
  - Inputs are ignored outside IDLE. A req that drops before it is granted is lost without error.
- Starvation:
  - With both ports requesting continuously, grants alternate 0, 1, 0, 1.
- Reset mid-cycle:
  - The next edge with rst_l = 0 forces reset values immediately: strobes negated, bus hi-Z, no done pulse.
  - The aborted write leaves SRAM contents undefined.
- A read never drives ram_data_ext at any point, which prevents bus contention.
- Address and ce never change while we_l = 0 or oe_l = 0.

Decomposition:
- Shared constants file sram_defs.vh:
  - state encodings ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD;
  - port indices PORT_SPI = 0, PORT_AUX = 1;
  - default ADDR_W and DATA_W.
- One natural sub-module, sram_cycle_fsm:
  - single-requester SETUP/STROBE/HOLD sequencer with pins and tristate;
  - input handshake start/we/addr/wdata, outputs done/rdata.
- The sram_arbiter top adds round-robin selection, the input mux and done demux.

Test Plan:
- Reset then idle 10 cycles -> ce_l = 1, ce2 = 0, we_l = 1, oe_l = 1, bus hi-Z, busy = 00, no done.
- p0 write addr 0x0006C, data 0x73 -> SETUP drives 0x0006C/0x73 with ce active; we_l low for exactly 2 cycles; p0_done at N+4; data driven through HOLD; bus hi-Z afterwards.
- Behavioural SRAM model preloaded 0x1A5A5 = 0x3C; p0 read 0x1A5A5 -> oe_l low for 2 cycles, bus never driven by the block, rdata = 0x3C with p0_done at N+4.
- p0 and p1 both raised in the same IDLE, each held for 3 accesses -> grant order 0, 1, 0, 1, 0, 1; one IDLE cycle between accesses; busy one-hot during each access.
- rst_l low during the first STROBE cycle of a p1 write -> at that edge we_l = 1, ce_l = 1, bus hi-Z; no p1_done; first post-reset tie goes to port 0.
- STROBE_CYC = 1 build, p1 read then p1 write back-to-back -> done at N+3 each; no cycle where oe_l and the data drive overlap.
